// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling feeding a show-ahead byte FIFO.
// Sticky framing/overrun flags; a set event beats a same-cycle clear.
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ  = 27_000_000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned FIFO_AW   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_pin,
    output logic [7:0]         rd_data,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               framing_err,
    output logic               overrun,
    input  logic               err_clear
);

    localparam int unsigned BitCycles = CLK_FREQ / BAUD_RATE;
    localparam int unsigned Half      = BitCycles / 2;
    localparam int unsigned Depth     = 2 ** FIFO_AW;

    localparam logic [15:0]        BitLast  = 16'(BitCycles - 1);
    localparam logic [15:0]        HalfLast = 16'(Half - 1);
    localparam logic [15:0]        CntOne   = 16'd1;
    localparam logic [FIFO_AW:0]   DepthCnt = (FIFO_AW + 1)'(Depth);
    localparam logic [FIFO_AW:0]   CountOne = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PtrOne   = FIFO_AW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizer. Resetting to 1 makes a line held low at reset
    // release look like a start edge, which START then validates.
    // ------------------------------------------------------------------
    logic rx_meta_q, rx_s_q, rx_d_q;
    logic fall_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_pin;
            rx_s_q    <= rx_meta_q;
            rx_d_q    <= rx_s_q;
        end
    end

    assign fall_edge = rx_d_q & ~rx_s_q;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_e      state_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        framing_err_q;

    logic stop_sample;
    logic byte_valid;
    logic frame_bad;

    assign stop_sample = (state_q == StStop) && (cnt_q == BitLast);
    assign byte_valid  = stop_sample & rx_s_q;
    assign frame_bad   = stop_sample & ~rx_s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            framing_err_q <= 1'b0;
        end else begin
            if (frame_bad) begin
                framing_err_q <= 1'b1;
            end else if (err_clear) begin
                framing_err_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (fall_edge) begin
                        cnt_q   <= '0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (cnt_q == HalfLast) begin
                        if (rx_s_q) begin
                            state_q <= StIdle;
                        end else begin
                            cnt_q     <= '0;
                            bit_idx_q <= '0;
                            state_q   <= StData;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StData: begin
                    if (cnt_q == BitLast) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_s_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StStop: begin
                    if (cnt_q == BitLast) begin
                        cnt_q   <= '0;
                        state_q <= rx_s_q ? StIdle : StBreak;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StBreak: begin
                    // One framing error per low period, however long the line stays low.
                    if (rx_s_q) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign framing_err = framing_err_q;

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------
    logic [7:0]         mem_q [Depth];
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               overrun_q, overrun_d;

    logic empty, full, pop, push, drop;

    assign empty = (count_q == '0);
    assign full  = (count_q == DepthCnt);
    assign pop   = ~empty & rd_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push  = byte_valid & (~full | pop);
    assign drop  = byte_valid & full & ~pop;

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (push && !pop) begin
            count_d = count_q + CountOne;
        end else if (pop && !push) begin
            count_d = count_q - CountOne;
        end

        if (drop) begin
            overrun_d = 1'b1;
        end else if (err_clear) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage needs no reset: rd_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign rd_data    = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign rd_valid   = ~empty;
    assign fifo_count = count_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo at a scaled bit rate (16 clocks per bit); expected
// results come from a byte-queue model of the receiver's rules.
module tb_uart_rx_fifo;

    localparam int unsigned ClkFreq   = 160;
    localparam int unsigned BaudRate  = 10;
    localparam int unsigned FifoAw    = 4;
    localparam int unsigned Depth     = 2 ** FifoAw;
    localparam int unsigned Bit       = ClkFreq / BaudRate;
    localparam int unsigned Half      = Bit / 2;
    // Edges from the first line-low drive to the stop-sample edge (2 sync + 1 detect).
    localparam int unsigned StopEdge  = 3 + Half + 9 * Bit;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rx_pin;
    logic [7:0]      rd_data;
    logic            rd_valid;
    logic            rd_ready;
    logic [FifoAw:0] fifo_count;
    logic            framing_err;
    logic            overrun;
    logic            err_clear;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic       exp_ovr;
    logic       exp_ferr;

    uart_rx_fifo #(
        .CLK_FREQ (ClkFreq),
        .BAUD_RATE(BaudRate),
        .FIFO_AW  (FifoAw)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_pin     (rx_pin),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .fifo_count (fifo_count),
        .framing_err(framing_err),
        .overrun    (overrun),
        .err_clear  (err_clear)
    );

    always #5 clk = ~clk;

    initial begin
        #(10 * 100000);
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame starts right after the next rising edge; returns #1 after the end of the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(posedge clk); #1 rx_pin = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (Bit) @(posedge clk);
            #1 rx_pin = b[i];
        end
        repeat (Bit) @(posedge clk);
        #1 rx_pin = stop_bit;
        repeat (Bit) @(posedge clk);
        #1;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop_ok);
        if (!stop_ok) begin
            exp_ferr = 1'b1;
        end else if (exp_q.size() < Depth) begin
            exp_q.push_back(b);
        end else begin
            exp_ovr = 1'b1;
        end
    endtask

    // Raises rd_ready (sel 0) or err_clear (sel 1) for exactly the stop-sample cycle
    // of a send_frame started at the same time.
    task automatic pulse_at_stop(input int sel);
        @(posedge clk);
        repeat (StopEdge - 1) @(posedge clk);
        #1;
        if (sel == 0) rd_ready = 1'b1;
        else          err_clear = 1'b1;
        @(posedge clk);
        #1;
        rd_ready  = 1'b0;
        err_clear = 1'b0;
    endtask

    task automatic clear_flags();
        err_clear = 1'b1;
        @(posedge clk);
        #1 err_clear = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_count"}, 32'(fifo_count), 32'(exp_q.size()));
        check_eq({tag, "_valid"}, 32'(rd_valid), 32'(exp_q.size() != 0));
        check_eq({tag, "_ferr"}, 32'(framing_err), 32'(exp_ferr));
        check_eq({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
    endtask

    task automatic pop_one(input string tag);
        check_eq({tag, "_pvalid"}, 32'(rd_valid), 32'd1);
        check_eq({tag, "_pdata"}, 32'(rd_data), 32'(exp_q[0]));
        rd_ready = 1'b1;
        @(posedge clk);
        #1 rd_ready = 1'b0;
        void'(exp_q.pop_front());
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < Depth + 1; i++) begin
            if (exp_q.size() == 0) break;
            check_eq({tag, "_dcount"}, 32'(fifo_count), 32'(exp_q.size()));
            pop_one(tag);
        end
        check_eq({tag, "_evalid"}, 32'(rd_valid), 32'd0);
        check_eq({tag, "_ecount"}, 32'(fifo_count), 32'd0);
        check_eq({tag, "_edata"}, 32'(rd_data), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        logic       ok;
        int         nfr;

        rx_pin    = 1'b1;
        rd_ready  = 1'b0;
        err_clear = 1'b0;
        rst_n     = 1'b0;
        exp_ovr   = 1'b0;
        exp_ferr  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_data", 32'(rd_data), 32'd0);
        check_state("rst");
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 check_state("post_rst");

        // Single byte with exact push latency
        fork
            send_frame(8'h55, 1'b1);
            begin
                @(posedge clk);
                repeat (StopEdge - 1) @(posedge clk);
                #1 check_eq("single_pre_valid", 32'(rd_valid), 32'd0);
                @(posedge clk);
                #1;
                check_eq("single_valid", 32'(rd_valid), 32'd1);
                check_eq("single_data", 32'(rd_data), 32'h55);
                check_eq("single_count", 32'(fifo_count), 32'd1);
            end
        join
        model_frame(8'h55, 1'b1);
        drain("single");

        // Burst of 17 with overrun
        for (int i = 0; i <= 16; i++) begin
            send_frame(8'(i), 1'b1);
            model_frame(8'(i), 1'b1);
        end
        check_state("burst");
        drain("burst");
        clear_flags();
        check_state("burst_clr");

        // Full FIFO with a pop in the stop-sample cycle
        for (int i = 0; i < Depth; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            model_frame(b, 1'b1);
        end
        fork
            send_frame(8'hA5, 1'b1);
            pulse_at_stop(0);
        join
        void'(exp_q.pop_front());
        model_frame(8'hA5, 1'b1);
        check_state("fullpop");
        drain("fullpop");

        // Glitch shorter than half a bit
        @(posedge clk); #1 rx_pin = 1'b0;
        repeat (Half / 2) @(posedge clk);
        #1 rx_pin = 1'b1;
        repeat (3 * Bit) @(posedge clk);
        #1 check_state("glitch");

        // Framing error, then line held low: only one error
        send_frame(8'h3C, 1'b0);
        model_frame(8'h3C, 1'b0);
        check_state("frame");
        clear_flags();
        repeat (3 * Bit) @(posedge clk);
        #1 check_state("frame_low");
        rx_pin = 1'b1;
        repeat (2 * Bit) @(posedge clk);
        #1 check_state("frame_rel");

        // Set beats clear in the same cycle
        fork
            send_frame(8'h3C, 1'b0);
            pulse_at_stop(1);
        join
        model_frame(8'h3C, 1'b0);
        rx_pin = 1'b1;
        repeat (4) @(posedge clk);
        #1 check_state("prio");

        // Reset during data bit 4, with a byte queued and a flag set beforehand
        send_frame(8'h11, 1'b1);
        model_frame(8'h11, 1'b1);
        check_state("pre_mid_rst");
        fork
            send_frame(8'hF0, 1'b1);
            begin
                @(posedge clk);
                repeat (Bit * 5 + 2) @(posedge clk);
                #1 rst_n = 1'b0;
                repeat (10) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        join
        exp_q.delete();
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        check_eq("midrst_data", 32'(rd_data), 32'd0);
        check_state("midrst");
        repeat (4) @(posedge clk);
        send_frame(8'hC3, 1'b1);
        model_frame(8'hC3, 1'b1);
        check_state("after_rst");
        drain("after_rst");

        // Randomized traffic with occasional bad stop bits and random consumer pops
        for (int r = 0; r < 4; r++) begin
            nfr = int'($urandom_range(1, 20));
            for (int f = 0; f < nfr; f++) begin
                b  = 8'($urandom);
                ok = ($urandom_range(0, 7) != 0);
                send_frame(b, ok);
                model_frame(b, ok);
                rx_pin = 1'b1;
                repeat ($urandom_range(4, 10)) @(posedge clk);
                #1;
                for (int p = int'($urandom_range(0, 2)); p > 0; p--) begin
                    if (exp_q.size() != 0) pop_one("rnd");
                end
            end
            check_state("rnd_end");
            drain("rnd");
            clear_flags();
            check_state("rnd_clr");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
